// File: rtl/board_disp_if.sv
// Board display bundle: snapshot source, scan controls and the multiplexed LED drive.
// The game core is the master and the display scanner is the slave.
interface board_disp_if;
  logic [63:0] board;
  logic        load;
  logic        hold;
  logic        flash;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [3:0]  row_led;

  modport master (output board, load, hold, flash, input seg_n, an_n, row_led);
  modport slave  (input board, load, hold, flash, output seg_n, an_n, row_led);
endinterface

// File: rtl/board_disp.sv
// Multiplexed 4-digit display of one 2048-board row at a time; BOARD_DISP_BLANK_ZERO_EN blanks empty cells.
// Outputs are registered one cycle after the scan state; there is no backpressure, load is never refused.
module board_disp #(
  parameter int REFRESH_DIV = 1000,
  parameter int ROW_DWELL   = 256
) (
  input logic         clk,
  input logic         rst_n,
  board_disp_if.slave bus
);

  localparam logic [15:0] REF_MAX   = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] FRM_MAX   = 16'(ROW_DWELL - 1);
  localparam logic [15:0] FRM_BLINK = 16'(ROW_DWELL / 2);

  logic [63:0] snap_q, snap_d;
  logic [15:0] refresh_q, refresh_d;
  logic [15:0] frame_q, frame_d;
  logic [1:0]  digit_q, digit_d;
  logic [1:0]  row_q, row_d;
  logic [6:0]  seg_n_q, seg_n_d;
  logic [3:0]  an_n_q, an_n_d;
  logic [3:0]  row_led_q, row_led_d;

  logic        ref_tc, dig_tc, frm_tc, blank;
  logic [3:0]  cell_exp;

  function automatic logic [6:0] glyph(input logic [3:0] e);
    logic [6:0] g;
    case (e)
`ifdef BOARD_DISP_BLANK_ZERO_EN
      4'd0:    g = 7'h7F;
`else
      4'd0:    g = 7'h40;
`endif
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      4'd10:   g = 7'h08;
      4'd11:   g = 7'h03;
      default: g = 7'h3F;
    endcase
    return g;
  endfunction

  always_comb begin
    snap_d    = bus.load ? bus.board : snap_q;
    ref_tc    = (refresh_q == REF_MAX);
    dig_tc    = ref_tc && (digit_q == 2'd3);
    frm_tc    = dig_tc && (frame_q == FRM_MAX);

    refresh_d = ref_tc ? 16'd0 : refresh_q + 16'd1;
    digit_d   = ref_tc ? digit_q + 2'd1 : digit_q;
    frame_d   = frame_q;
    if (dig_tc) frame_d = frm_tc ? 16'd0 : frame_q + 16'd1;
    // hold only freezes the row; the scan keeps running so the digits never go dark
    row_d     = (frm_tc && !bus.hold) ? row_q + 2'd1 : row_q;

    cell_exp  = snap_q[{row_q, digit_q, 2'b00} +: 4];
    blank     = bus.flash && (frame_q >= FRM_BLINK);
    seg_n_d   = blank ? 7'h7F : glyph(cell_exp);
    an_n_d    = blank ? 4'hF : ~(4'b0001 << digit_q);
    row_led_d = 4'b0001 << row_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q    <= '0;
      refresh_q <= '0;
      frame_q   <= '0;
      digit_q   <= '0;
      row_q     <= '0;
      seg_n_q   <= 7'h7F;
      an_n_q    <= 4'hF;
      row_led_q <= 4'b0001;
    end else begin
      snap_q    <= snap_d;
      refresh_q <= refresh_d;
      frame_q   <= frame_d;
      digit_q   <= digit_d;
      row_q     <= row_d;
      seg_n_q   <= seg_n_d;
      an_n_q    <= an_n_d;
      row_led_q <= row_led_d;
    end
  end

  assign bus.seg_n   = seg_n_q;
  assign bus.an_n    = an_n_q;
  assign bus.row_led = row_led_q;

endmodule

// File: tb/tb_board_disp.sv
// Directed bench for board_disp at REFRESH_DIV=4, ROW_DWELL=2 (digit 4, frame 16, row 32 cycles).
// Sample k is taken 1 ns after the k-th rising edge following reset release.
module tb_board_disp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

`ifdef BOARD_DISP_BLANK_ZERO_EN
  localparam logic [6:0] ZERO_G = 7'h7F;
`else
  localparam logic [6:0] ZERO_G = 7'h40;
`endif

  board_disp_if bus();

  board_disp #(.REFRESH_DIV(4), .ROW_DWELL(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.hold = 1'b0;
    bus.flash = 1'b0;
    step();
    step();
    chk("rst_seg", 16'(bus.seg_n), 16'h7F);
    chk("rst_an", 16'(bus.an_n), 16'hF);
    chk("rst_row", 16'(bus.row_led), 16'h1);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  int blanks;

  initial begin
    bus.board = '0;
    bus.load = 1'b0;
    bus.hold = 1'b0;
    bus.flash = 1'b0;

    // free run from reset, snapshot empty
    do_reset();
    run_to(1);  chk("fr_an0", 16'(bus.an_n), 16'hE);
                chk("fr_seg0", 16'(bus.seg_n), 16'(ZERO_G));
                chk("fr_row0", 16'(bus.row_led), 16'h1);
    run_to(5);  chk("fr_an1", 16'(bus.an_n), 16'hD);
    run_to(9);  chk("fr_an2", 16'(bus.an_n), 16'hB);
    run_to(13); chk("fr_an3", 16'(bus.an_n), 16'h7);
    run_to(17); chk("fr_anwrap", 16'(bus.an_n), 16'hE);
    run_to(32); chk("fr_row_pre", 16'(bus.row_led), 16'h1);
    run_to(33); chk("fr_row_step", 16'(bus.row_led), 16'h2);
    run_to(128); chk("fr_row3", 16'(bus.row_led), 16'h8);
    run_to(129); chk("fr_row_wrap", 16'(bus.row_led), 16'h1);

    // snapshot load and glyph decode
    do_reset();
    bus.board = {32'h0, 16'hC902, 16'hDAB1};
    bus.load = 1'b1;
    run_to(1);  chk("ld_old_snap", 16'(bus.seg_n), 16'(ZERO_G));
    bus.load = 1'b0;
    run_to(2);  chk("ld_d0", 16'(bus.seg_n), 16'h79);
                chk("ld_an0", 16'(bus.an_n), 16'hE);
    run_to(5);  chk("ld_d1", 16'(bus.seg_n), 16'h03);
    run_to(9);  chk("ld_d2", 16'(bus.seg_n), 16'h08);
    run_to(13); chk("ld_d3", 16'(bus.seg_n), 16'h3F);
    run_to(33); chk("ld_r1d0", 16'(bus.seg_n), 16'h24);
    run_to(37); chk("ld_r1d1", 16'(bus.seg_n), 16'(ZERO_G));
    run_to(41); chk("ld_r1d2", 16'(bus.seg_n), 16'h10);
    run_to(45); chk("ld_r1d3", 16'(bus.seg_n), 16'h3F);
    bus.board = {32'h0, 16'h5902, 16'hDAB1};
    bus.load = 1'b1;
    run_to(46); chk("mid_old", 16'(bus.seg_n), 16'h3F);
    bus.load = 1'b0;
    run_to(47); chk("mid_new", 16'(bus.seg_n), 16'h12);
                chk("mid_an", 16'(bus.an_n), 16'h7);
    run_to(49); chk("mid_an_wrap", 16'(bus.an_n), 16'hE);
                chk("mid_row", 16'(bus.row_led), 16'h2);

    // reset mid-row with a concurrent load: reset wins, snapshot is cleared
    rst_n = 1'b0;
    bus.board = {16'h1111, 16'h1111, 16'h1111, 16'h1111};
    bus.load = 1'b1;
    step();
    chk("mr_seg", 16'(bus.seg_n), 16'h7F);
    chk("mr_an", 16'(bus.an_n), 16'hF);
    chk("mr_row", 16'(bus.row_led), 16'h1);
    rst_n = 1'b1;
    bus.load = 1'b0;
    cyc = 0;
    run_to(1); chk("mr_snap0", 16'(bus.seg_n), 16'(ZERO_G));
               chk("mr_an0", 16'(bus.an_n), 16'hE);
    run_to(2); chk("mr_snap0b", 16'(bus.seg_n), 16'(ZERO_G));

    // hold across a row boundary
    do_reset();
    bus.hold = 1'b1;
    run_to(33); chk("hd_row", 16'(bus.row_led), 16'h1);
                chk("hd_an", 16'(bus.an_n), 16'hE);
    run_to(40); chk("hd_scan", 16'(bus.an_n), 16'hD);
    bus.hold = 1'b0;
    run_to(64); chk("hd_row_pre", 16'(bus.row_led), 16'h1);
    run_to(65); chk("hd_row_adv", 16'(bus.row_led), 16'h2);

    // flash: second half of each row's frames is blank
    do_reset();
    bus.flash = 1'b1;
    blanks = 0;
    for (int k = 1; k <= 32; k++) begin
      run_to(k);
      if (bus.an_n == 4'hF) blanks++;
      if (k == 1)  chk("fl_an_on", 16'(bus.an_n), 16'hE);
      if (k == 17) begin
        chk("fl_an_off", 16'(bus.an_n), 16'hF);
        chk("fl_seg_off", 16'(bus.seg_n), 16'h7F);
      end
    end
    chk("fl_blank_cnt", 16'(blanks), 16'd16);
    chk("fl_row_k32", 16'(bus.row_led), 16'h1);
    run_to(33); chk("fl_row_adv", 16'(bus.row_led), 16'h2);
                chk("fl_an_back", 16'(bus.an_n), 16'hE);
    run_to(49); chk("fl_an_off2", 16'(bus.an_n), 16'hF);
                chk("fl_row_off2", 16'(bus.row_led), 16'h2);
    bus.flash = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
